// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: default operand widths and the divider FSM states.
package arith_pkg;

    localparam int unsigned DEF_DIVIDEND_W = 4;
    localparam int unsigned DEF_DIVISOR_W  = 2;

    // Quotient reported for a divide by zero; truncated to the quotient width at use.
    localparam logic [31:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

endpackage

// File: rtl/sequential_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the sequential divider.
interface sequential_divider_if #(
    parameter int unsigned DIVIDEND_W = arith_pkg::DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = arith_pkg::DEF_DIVISOR_W
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sequential_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, compare, subtract.
module div_step #(
    parameter int unsigned DIVISOR_W = arith_pkg::DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W-1:0] r_in,
    input  logic                 msb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] r_next_c,
    output logic                 q_bit_c
);
    logic [DIVISOR_W:0] t;
    logic [DIVISOR_W:0] d_ext;

    // Compare at DIVISOR_W+1 bits; the restored remainder always fits DIVISOR_W bits.
    always_comb begin
        t        = {r_in, msb};
        d_ext    = {1'b0, divisor};
        q_bit_c  = (t >= d_ext);
        r_next_c = q_bit_c ? DIVISOR_W'(t - d_ext) : t[DIVISOR_W-1:0];
    end
endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock behind a start/busy/done handshake.
module sequential_divider
    import arith_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
    input logic                 clk,
    input logic                 rst,
    sequential_divider_if.slave bus
);
    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    div_state_e            state;
    logic [DIVIDEND_W-1:0] q_sr;
    logic [DIVIDEND_W-1:0] q_sr_next;
    logic [DIVISOR_W-1:0]  r;
    logic [DIVISOR_W-1:0]  r_next;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [CNT_W-1:0]      count;
    logic                  q_bit;

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .r_in     (r),
        .msb      (q_sr[DIVIDEND_W-1]),
        .divisor  (divisor_q),
        .r_next_c (r_next),
        .q_bit_c  (q_bit)
    );

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign q_sr_next = DIVIDEND_W'({q_sr, q_bit});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            q_sr            <= '0;
            r               <= '0;
            divisor_q       <= '0;
            count           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            bus.quotient    <= DIVIDEND_W'(DIV0_QUOTIENT);
                            bus.remainder   <= '0;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end else begin
                            q_sr      <= bus.dividend;
                            r         <= '0;
                            divisor_q <= bus.divisor;
                            count     <= CNT_W'(DIVIDEND_W - 1);
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_sr  <= q_sr_next;
                    r     <= r_next;
                    count <= count - CNT_W'(1);
                    if (count == '0) begin
                        bus.quotient    <= q_sr_next;
                        bus.remainder   <= r_next;
                        bus.div_by_zero <= 1'b0;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// Directed and exhaustive checks of the sequential divider against hand-computed and modelled results.
module tb_sequential_divider;
    localparam int unsigned DW = 4;
    localparam int unsigned VW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sequential_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

    sequential_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits at negedges for done; cyc is the number of negedges waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge with the DUT idle; finishes one negedge after the done pulse.
    task automatic run_div(input string tag, input logic [3:0] dvd, input logic [1:0] dvs,
                           input logic [3:0] eq, input logic [1:0] er, input logic edz,
                           input int elat);
        int lat;
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = ~dvd;
        bus.divisor  = ~dvs;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dz"}, 32'(bus.div_by_zero), 32'(edz));
        if (dvs != 2'd0)
            check({tag, "_mulback"}, 32'(bus.quotient) * 32'(dvs) + 32'(bus.remainder), 32'(dvd));
        @(negedge clk);
        check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          gap;
        int          eg;
        logic [3:0]  dvd;
        logic [1:0]  dvs;
        logic [3:0]  eq;
        logic [1:0]  er;
        logic        edz;
        logic [3:0]  hq;
        logic [1:0]  hr;
        logic        hdz;
        logic        stable;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_dz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("d6_3",  4'd6,  2'd3, 4'd2,  2'd0, 1'b0, DW);
        run_div("d2_1",  4'd2,  2'd1, 4'd2,  2'd0, 1'b0, DW);
        run_div("d15_2", 4'd15, 2'd2, 4'd7,  2'd1, 1'b0, DW);
        run_div("d13_3", 4'd13, 2'd3, 4'd4,  2'd1, 1'b0, DW);
        run_div("d0_3",  4'd0,  2'd3, 4'd0,  2'd0, 1'b0, DW);
        run_div("d9_0",  4'd9,  2'd0, 4'hF,  2'd0, 1'b1, 0);
        run_div("d9_3",  4'd9,  2'd3, 4'd3,  2'd0, 1'b0, DW);

        // Second request while busy must be dropped.
        bus.start    = 1'b1;
        bus.dividend = 4'd15;
        bus.divisor  = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd8;
        bus.divisor  = 2'd2;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_q", 32'(bus.quotient), 32'd5);
        check("ign_r", 32'(bus.remainder), 32'd0);
        check("ign_busy", 32'(bus.busy), 32'd0);

        // Asynchronous abort in the middle of CALC.
        bus.start    = 1'b1;
        bus.dividend = 4'd14;
        bus.divisor  = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_q", 32'(bus.quotient), 32'd0);
        check("abort_r", 32'(bus.remainder), 32'd0);
        check("abort_dz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_div("d14_3", 4'd14, 2'd3, 4'd4, 2'd2, 1'b0, DW);

        // Exhaustive sweep with start held high; operands advance at each done pulse.
        bus.start    = 1'b1;
        bus.dividend = 4'd0;
        bus.divisor  = 2'd0;
        hq  = '0;
        hr  = '0;
        hdz = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dvd = 4'(i >> 2);
            dvs = 2'(i);
            if (dvs == 2'd0) begin
                eq  = 4'hF;
                er  = 2'd0;
                edz = 1'b1;
            end else begin
                eq  = dvd / 4'(dvs);
                er  = 2'(dvd % 4'(dvs));
                edz = 1'b0;
            end
            eg     = ((i == 0) ? 1 : 2) + ((dvs != 2'd0) ? DW : 0);
            stable = 1'b1;
            gap    = 0;
            do begin
                @(negedge clk);
                gap++;
                if (bus.done !== 1'b1 &&
                    (bus.quotient !== hq || bus.remainder !== hr || bus.div_by_zero !== hdz))
                    stable = 1'b0;
            end while (bus.done !== 1'b1 && gap < 20);
            check($sformatf("sw%0d_done", i), 32'(bus.done), 32'd1);
            check($sformatf("sw%0d_gap", i), 32'(gap), 32'(eg));
            check($sformatf("sw%0d_q", i), 32'(bus.quotient), 32'(eq));
            check($sformatf("sw%0d_r", i), 32'(bus.remainder), 32'(er));
            check($sformatf("sw%0d_dz", i), 32'(bus.div_by_zero), 32'(edz));
            if (i > 0) check($sformatf("sw%0d_stable", i), 32'(stable), 32'd1);
            hq  = bus.quotient;
            hr  = bus.remainder;
            hdz = bus.div_by_zero;
            if (i < 63) begin
                bus.dividend = 4'((i + 1) >> 2);
                bus.divisor  = 2'(i + 1);
            end else begin
                bus.start = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        check("end_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Multi-cycle restoring divider, the inverse operation of the team's 2x2 combinational multiplier. It takes a product-width dividend and an operand-width divisor and produces quotient and remainder. It resolves one quotient bit per clock. A start/busy/done handshake lets it sit beside the multiplier in the arithmetic datapath, with results checked by a multiply-back (quotient x divisor + remainder = dividend).

Parameters:
DIVIDEND_W, 4, dividend and quotient width (product width of the 2x2 multiplier)
DIVISOR_W, 2, divisor and remainder width (operand width of the multiplier)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
dividend  in  DIVIDEND_W  numerator, unsigned; captured on accepted start
divisor  in  DIVISOR_W  denominator, unsigned; captured on accepted start
busy  out  1  high while a division is in progress (CALC and DONE states)
done  out  1  one-cycle pulse; results valid from this cycle on
quotient  out  DIVIDEND_W  unsigned quotient
remainder  out  DIVISOR_W  unsigned remainder, always < divisor when divisor != 0
div_by_zero  out  1  error flag for the last completed operation

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset (asynchronous, any state, including mid-calculation): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared. No done pulse is produced for an aborted operation.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE, start=1 at edge k, divisor!=0:
  - Capture operands into internal registers: shift register q_sr=dividend, partial remainder r=0 (DIVISOR_W+1 bits), count=DIVIDEND_W-1.
  - Go to CALC; busy=1 from edge k.
- IDLE, start=1 at edge k, divisor==0:
  - Go directly to DONE; busy=1 from edge k.
  - Result: quotient=all ones, remainder=0, div_by_zero=1.
- CALC, each edge (restoring step):
  - t = {r[DIVISOR_W-1:0], q_sr[MSB]}.
  - If t >= {0,divisor}: r = t - divisor, shift 1 into q_sr LSB. Otherwise: r = t, shift 0.
  - Run exactly DIVIDEND_W steps. On the last step (count==0), load quotient=final q_sr, remainder=final r[DIVISOR_W-1:0], div_by_zero=0, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy deasserts on the same edge that clears done.
- Latency:
  - Normal: done high in the cycle following edge k+DIVIDEND_W (4 CALC edges after the accept edge for defaults).
  - Divide by zero: done high in the cycle following edge k.
- Output holding: quotient, remainder and div_by_zero change only on completion. They hold their values through IDLE until the next completion. Intermediate values are never visible on the outputs.
- start while busy=1 (CALC or DONE): ignored, with no queuing. Operand inputs may change freely while busy.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE. Back-to-back throughput is one result per DIVIDEND_W+2 cycles.
- Arithmetic width: the partial remainder needs DIVISOR_W+1 bits so the compare cannot overflow. Quotient fits DIVIDEND_W bits for any divisor >= 1.
- dividend=0 with divisor!=0: full latency, quotient=0, remainder=0.

Decomposition:
- Shared package arith_pkg:
  - State enum (IDLE, CALC, DONE).
  - DIVIDEND_W/DIVISOR_W default constants, shared with the multiplier.
  - DIV0_QUOTIENT constant (all ones).
- One natural sub-module: div_step, a combinational single restoring step (shift, compare, subtract) returning the next r and the quotient bit. The top holds the FSM, counter and registers.

Test Plan:
- dividend=6 (4'b0110), divisor=3 (2'b11), start pulse -> busy 1, done after 5 cycles, quotient=2, remainder=0, div_by_zero=0 (inverts 3x2).
- dividend=2, divisor=1 -> quotient=2, remainder=0. Then dividend=15, divisor=2 -> quotient=7, remainder=1. Then 13/3 -> quotient=4, remainder=1. Each must satisfy quotient*divisor+remainder=dividend.
- divisor=0, dividend=9 -> done in the cycle after the accept edge; quotient=4'b1111, remainder=0, div_by_zero=1. A following 9/3 clears the flag: quotient=3, remainder=0, div_by_zero=0.
- Start 15/3, then pulse start with 8/2 two cycles later while busy -> the second request is ignored; the single result is quotient=5, remainder=0, with only one done pulse.
- Start 14/3, assert rst at cycle 2 of CALC -> all outputs 0 immediately (asynchronous), no done. After release, 14/3 -> quotient=4, remainder=2.
- Exhaustive sweep of all 16x4 operand pairs with start held high -> every result matches the reference model. Results are spaced DIVIDEND_W+2 cycles apart, and outputs are stable between done pulses.
